sdram_multiport_frontend: RTL and testbench

- Multi-port Avalon-MM front-end for the SDRAM access engine, placed between N Avalon slave ports and the engine's single bus_req_*/bus_resp_* interface.
- Arbitrates requests round-robin through a one-entry request slot.
- Tracks outstanding reads in an in-order tag FIFO so each read response is routed back to the port that issued it.
- Generalises the single-port controller top to NUM_PORTS channels with parametrised widths and read depth.

---
 rtl/sdram_multiport_frontend_if.sv | 38 +++
 rtl/sdram_multiport_frontend.sv | 113 +++++++++++
 tb/tb_sdram_multiport_frontend.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_multiport_frontend_if.sv
// sdram_multiport_frontend_if: Avalon port bundle and engine request/response bus of the multiport front-end
interface sdram_multiport_frontend_if #(
    parameter int NUM_PORTS = 2,
    parameter int AW        = 24,
    parameter int DW        = 16,
    parameter int BYTE      = DW / 8
);
    logic [NUM_PORTS-1:0]      avs_read;
    logic [NUM_PORTS-1:0]      avs_write;
    logic [NUM_PORTS*AW-1:0]   avs_address;
    logic [NUM_PORTS*DW-1:0]   avs_writedata;
    logic [NUM_PORTS*BYTE-1:0] avs_byteenable;
    logic [NUM_PORTS-1:0]      avs_waitrequest;
    logic [DW-1:0]             avs_readdata;
    logic [NUM_PORTS-1:0]      avs_readdatavalid;
    logic                      bus_req_valid;
    logic                      bus_req_ready;
    logic                      bus_req_write;
    logic [AW-1:0]             bus_req_address;
    logic [DW-1:0]             bus_req_writedata;
    logic [BYTE-1:0]           bus_req_byteenable;
    logic                      bus_resp_valid;
    logic [DW-1:0]             bus_resp_readdata;

    modport slave (
        input  avs_read, avs_write, avs_address, avs_writedata, avs_byteenable,
        output avs_waitrequest, avs_readdata, avs_readdatavalid,
        output bus_req_valid, bus_req_write, bus_req_address, bus_req_writedata, bus_req_byteenable,
        input  bus_req_ready, bus_resp_valid, bus_resp_readdata
    );

    modport master (
        output avs_read, avs_write, avs_address, avs_writedata, avs_byteenable,
        input  avs_waitrequest, avs_readdata, avs_readdatavalid,
        input  bus_req_valid, bus_req_write, bus_req_address, bus_req_writedata, bus_req_byteenable,
        output bus_req_ready, bus_resp_valid, bus_resp_readdata
    );
endinterface

// File: rtl/sdram_multiport_frontend.sv
// sdram_multiport_frontend: round-robin N-port Avalon front-end with one-entry request slot and in-order read tag FIFO
module sdram_multiport_frontend #(
    parameter int NUM_PORTS = 2,
    parameter int AW        = 24,
    parameter int DW        = 16,
    parameter int BYTE      = DW / 8,
    parameter int TAG_DEPTH = 8,
    parameter int PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     init_done_i,
    output logic                     tag_err_o,
    sdram_multiport_frontend_if.slave bus_if
);
    localparam int TW = $clog2(TAG_DEPTH);

    logic [NUM_PORTS-1:0] req, elig, gnt_oh;
    logic                 gnt, slot_free, tags_full, push, pop;
    logic [PW-1:0]        gnt_id, head;
    int                   idx;

    logic                 slot_vld_q, slot_vld_d, slot_wr_q, slot_wr_d;
    logic [AW-1:0]        slot_addr_q, slot_addr_d;
    logic [DW-1:0]        slot_wdata_q, slot_wdata_d;
    logic [BYTE-1:0]      slot_be_q, slot_be_d;
    logic [PW-1:0]        rr_q, rr_d;
    logic [PW-1:0]        tag_mem_q [TAG_DEPTH];
    logic [TW-1:0]        wp_q, rp_q;
    logic [TW:0]          cnt_q, cnt_d;
    logic [DW-1:0]        rdata_q;
    logic [NUM_PORTS-1:0] rdv_q;
    logic                 err_q;

    // Round-robin grant: first eligible port after the last winner, only when the slot can take it
    always_comb begin
        req       = bus_if.avs_read | bus_if.avs_write;
        tags_full = cnt_q == (TW+1)'(TAG_DEPTH);
        elig      = req & {NUM_PORTS{init_done_i}} & (bus_if.avs_write | {NUM_PORTS{!tags_full}});
        slot_free = !slot_vld_q || bus_if.bus_req_ready;
        gnt       = 1'b0;
        gnt_id    = '0;
        idx       = 0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            idx = (int'(rr_q) + i) % NUM_PORTS;
            if (!gnt && slot_free && elig[idx]) begin
                gnt    = 1'b1;
                gnt_id = PW'(idx);
            end
        end
        gnt_oh = gnt ? NUM_PORTS'(1) << gnt_id : '0;
    end

    // Next state of the slot, round-robin pointer and tag count; a write with read also set is a write
    always_comb begin
        push         = gnt && !bus_if.avs_write[gnt_id];
        pop          = bus_if.bus_resp_valid && cnt_q != '0;
        cnt_d        = cnt_q + (TW+1)'(push) - (TW+1)'(pop);
        rr_d         = gnt ? gnt_id : rr_q;
        slot_vld_d   = gnt || (slot_vld_q && !bus_if.bus_req_ready);
        slot_wr_d    = gnt ? bus_if.avs_write[gnt_id] : slot_wr_q;
        slot_addr_d  = gnt ? bus_if.avs_address[gnt_id*AW +: AW] : slot_addr_q;
        slot_wdata_d = gnt ? bus_if.avs_writedata[gnt_id*DW +: DW] : slot_wdata_q;
        slot_be_d    = gnt ? bus_if.avs_byteenable[gnt_id*BYTE +: BYTE] : slot_be_q;
        head         = tag_mem_q[rp_q];
    end

    // State registers; reset drops the slot and every pending tag
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_vld_q   <= 1'b0;
            slot_wr_q    <= 1'b0;
            slot_addr_q  <= '0;
            slot_wdata_q <= '0;
            slot_be_q    <= '0;
            rr_q         <= PW'(NUM_PORTS - 1);
            wp_q         <= '0;
            rp_q         <= '0;
            cnt_q        <= '0;
            rdata_q      <= '0;
            rdv_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            slot_vld_q   <= slot_vld_d;
            slot_wr_q    <= slot_wr_d;
            slot_addr_q  <= slot_addr_d;
            slot_wdata_q <= slot_wdata_d;
            slot_be_q    <= slot_be_d;
            rr_q         <= rr_d;
            cnt_q        <= cnt_d;
            if (push) wp_q <= wp_q + TW'(1);
            if (pop) rp_q <= rp_q + TW'(1);
            if (pop) rdata_q <= bus_if.bus_resp_readdata;
            rdv_q        <= pop ? NUM_PORTS'(1) << head : '0;
            err_q        <= err_q || (bus_if.bus_resp_valid && cnt_q == '0);
        end
    end

    // Tag storage needs no reset: the pointers define which entries are live
    always_ff @(posedge clk) begin
        if (push) tag_mem_q[wp_q] <= gnt_id;
    end

    assign bus_if.avs_waitrequest    = ~gnt_oh;
    assign bus_if.avs_readdata       = rdata_q;
    assign bus_if.avs_readdatavalid  = rdv_q;
    assign bus_if.bus_req_valid      = slot_vld_q;
    assign bus_if.bus_req_write      = slot_wr_q;
    assign bus_if.bus_req_address    = slot_addr_q;
    assign bus_if.bus_req_writedata  = slot_wdata_q;
    assign bus_if.bus_req_byteenable = slot_be_q;
    assign tag_err_o                 = err_q;
endmodule

// File: tb/tb_sdram_multiport_frontend.sv
// tb_sdram_multiport_frontend: directed scenarios for the two-port SDRAM front-end
module tb_sdram_multiport_frontend;
    localparam int NP = 2;
    localparam int AW = 24;
    localparam int DW = 16;
    localparam int BY = DW / 8;

    logic clk, reset, init_done_i, tag_err_o;
    int   vec, errs;

    sdram_multiport_frontend_if #(.NUM_PORTS(NP), .AW(AW), .DW(DW), .BYTE(BY)) ifc ();

    sdram_multiport_frontend #(.NUM_PORTS(NP), .AW(AW), .DW(DW), .BYTE(BY), .TAG_DEPTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .init_done_i (init_done_i),
        .tag_err_o   (tag_err_o),
        .bus_if      (ifc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idle();
        ifc.avs_read          = '0;
        ifc.avs_write         = '0;
        ifc.avs_address       = '0;
        ifc.avs_writedata     = '0;
        ifc.avs_byteenable    = '0;
        ifc.bus_req_ready     = 1'b0;
        ifc.bus_resp_valid    = 1'b0;
        ifc.bus_resp_readdata = '0;
    endtask

    task automatic test_reset();
        idle();
        reset       = 1'b1;
        init_done_i = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        vec++; if (ifc.bus_req_valid !== 1'b0) begin errs++; $display("FAIL rst_valid got %b exp 0", ifc.bus_req_valid); end
        vec++; if (ifc.avs_waitrequest !== 2'b11) begin errs++; $display("FAIL rst_wait got %b exp 11", ifc.avs_waitrequest); end
        vec++; if (ifc.avs_readdatavalid !== 2'b00) begin errs++; $display("FAIL rst_rdv got %b exp 00", ifc.avs_readdatavalid); end
        vec++; if (ifc.avs_readdata !== 16'h0) begin errs++; $display("FAIL rst_rdata got %h exp 0000", ifc.avs_readdata); end
        vec++; if (tag_err_o !== 1'b0) begin errs++; $display("FAIL rst_tagerr got %b exp 0", tag_err_o); end
        reset = 1'b0;
    endtask

    task automatic test_init();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            ifc.avs_read[0]          = 1'b1;
            ifc.avs_address[0 +: AW] = 24'h000100;
            #1;
            vec++; if (ifc.avs_waitrequest !== 2'b11) begin errs++; $display("FAIL init_wait[%0d] got %b exp 11", i, ifc.avs_waitrequest); end
            vec++; if (ifc.bus_req_valid !== 1'b0) begin errs++; $display("FAIL init_valid[%0d] got %b exp 0", i, ifc.bus_req_valid); end
        end
        @(negedge clk);
        init_done_i = 1'b1;
        #1;
        vec++; if (ifc.avs_waitrequest !== 2'b10) begin errs++; $display("FAIL init_grant got %b exp 10", ifc.avs_waitrequest); end
        @(negedge clk);
        ifc.avs_read          = '0;
        ifc.bus_req_ready     = 1'b1;
        ifc.bus_resp_valid    = 1'b1;
        ifc.bus_resp_readdata = 16'h1234;
        #1;
        vec++; if ({ifc.bus_req_valid, ifc.bus_req_write, ifc.bus_req_address} !== {2'b10, 24'h000100})
            begin errs++; $display("FAIL init_slot got %b%b %h exp 10 000100", ifc.bus_req_valid, ifc.bus_req_write, ifc.bus_req_address); end
        @(negedge clk);
        ifc.bus_resp_valid = 1'b0;
        #1;
        vec++; if (ifc.avs_readdatavalid !== 2'b01) begin errs++; $display("FAIL init_rdv got %b exp 01", ifc.avs_readdatavalid); end
        vec++; if (ifc.avs_readdata !== 16'h1234) begin errs++; $display("FAIL init_rdata got %h exp 1234", ifc.avs_readdata); end
        vec++; if (ifc.bus_req_valid !== 1'b0) begin errs++; $display("FAIL init_drain got %b exp 0", ifc.bus_req_valid); end
        @(negedge clk);
        #1;
        vec++; if (ifc.avs_readdatavalid !== 2'b00) begin errs++; $display("FAIL init_rdv_off got %b exp 00", ifc.avs_readdatavalid); end
        vec++; if (ifc.avs_readdata !== 16'h1234) begin errs++; $display("FAIL init_rdata_hold got %h exp 1234", ifc.avs_readdata); end
    endtask

    task automatic test_round_robin();
        logic [1:0]    exp_w;
        logic [AW-1:0] exp_a;
        logic [DW-1:0] exp_d;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) begin
                ifc.bus_req_ready         = 1'b1;
                ifc.avs_write             = 2'b11;
                ifc.avs_address[0 +: AW]  = 24'hA00000;
                ifc.avs_address[AW +: AW] = 24'hB00001;
                ifc.avs_writedata         = {16'h2222, 16'h1111};
                ifc.avs_byteenable        = 4'b1111;
            end
            #1;
            exp_w = (i % 2 == 0) ? 2'b01 : 2'b10;
            vec++; if (ifc.avs_waitrequest !== exp_w) begin errs++; $display("FAIL rr_wait[%0d] got %b exp %b", i, ifc.avs_waitrequest, exp_w); end
            if (i > 0) begin
                exp_a = (i % 2 == 0) ? 24'hA00000 : 24'hB00001;
                exp_d = (i % 2 == 0) ? 16'h1111 : 16'h2222;
                vec++; if ({ifc.bus_req_valid, ifc.bus_req_write, ifc.bus_req_address, ifc.bus_req_writedata} !== {2'b11, exp_a, exp_d})
                    begin errs++; $display("FAIL rr_slot[%0d] got %b%b %h %h exp 11 %h %h", i, ifc.bus_req_valid, ifc.bus_req_write, ifc.bus_req_address, ifc.bus_req_writedata, exp_a, exp_d); end
            end
        end
        @(negedge clk);
        ifc.avs_write = '0;
        #1;
        vec++; if ({ifc.bus_req_valid, ifc.bus_req_address} !== {1'b1, 24'hA00000}) begin errs++; $display("FAIL rr_last got %b %h exp 1 a00000", ifc.bus_req_valid, ifc.bus_req_address); end
        @(negedge clk);
        #1;
        vec++; if (ifc.bus_req_valid !== 1'b0) begin errs++; $display("FAIL rr_drain got %b exp 0", ifc.bus_req_valid); end
    endtask

    task automatic test_read_order();
        @(negedge clk);
        ifc.avs_read[1]           = 1'b1;
        ifc.avs_address[AW +: AW] = 24'h000010;
        #1;
        vec++; if (ifc.avs_waitrequest !== 2'b01) begin errs++; $display("FAIL ro_g1 got %b exp 01", ifc.avs_waitrequest); end
        @(negedge clk);
        ifc.avs_read             = 2'b01;
        ifc.avs_address[0 +: AW] = 24'h000020;
        #1;
        vec++; if (ifc.avs_waitrequest !== 2'b10) begin errs++; $display("FAIL ro_g0 got %b exp 10", ifc.avs_waitrequest); end
        vec++; if ({ifc.bus_req_write, ifc.bus_req_address} !== {1'b0, 24'h000010}) begin errs++; $display("FAIL ro_a1 got %b %h exp 0 000010", ifc.bus_req_write, ifc.bus_req_address); end
        @(negedge clk);
        ifc.avs_read          = '0;
        ifc.bus_resp_valid    = 1'b1;
        ifc.bus_resp_readdata = 16'hAAAA;
        #1;
        vec++; if (ifc.bus_req_address !== 24'h000020) begin errs++; $display("FAIL ro_a0 got %h exp 000020", ifc.bus_req_address); end
        vec++; if (ifc.avs_readdatavalid !== 2'b00) begin errs++; $display("FAIL ro_lat got %b exp 00", ifc.avs_readdatavalid); end
        @(negedge clk);
        ifc.bus_resp_readdata = 16'h5555;
        #1;
        vec++; if ({ifc.avs_readdatavalid, ifc.avs_readdata} !== {2'b10, 16'hAAAA}) begin errs++; $display("FAIL ro_r1 got %b %h exp 10 aaaa", ifc.avs_readdatavalid, ifc.avs_readdata); end
        @(negedge clk);
        ifc.bus_resp_valid = 1'b0;
        #1;
        vec++; if ({ifc.avs_readdatavalid, ifc.avs_readdata} !== {2'b01, 16'h5555}) begin errs++; $display("FAIL ro_r0 got %b %h exp 01 5555", ifc.avs_readdatavalid, ifc.avs_readdata); end
        @(negedge clk);
        #1;
        vec++; if (ifc.avs_readdatavalid !== 2'b00) begin errs++; $display("FAIL ro_idle got %b exp 00", ifc.avs_readdatavalid); end
    endtask

    task automatic test_tag_full();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            ifc.avs_read[0]          = 1'b1;
            ifc.avs_address[0 +: AW] = 24'h000300 + 24'(i);
            #1;
            vec++; if (ifc.avs_waitrequest !== 2'b10) begin errs++; $display("FAIL tf_rd[%0d] got %b exp 10", i, ifc.avs_waitrequest); end
        end
        @(negedge clk);
        ifc.avs_write[1]          = 1'b1;
        ifc.avs_address[AW +: AW] = 24'h000777;
        #1;
        vec++; if (ifc.avs_waitrequest !== 2'b01) begin errs++; $display("FAIL tf_wr_pass got %b exp 01", ifc.avs_waitrequest); end
        @(negedge clk);
        ifc.avs_write         = '0;
        ifc.bus_resp_valid    = 1'b1;
        ifc.bus_resp_readdata = 16'h0F0F;
        #1;
        vec++; if (ifc.avs_waitrequest !== 2'b11) begin errs++; $display("FAIL tf_stall got %b exp 11", ifc.avs_waitrequest); end
        @(negedge clk);
        ifc.bus_resp_valid = 1'b0;
        #1;
        vec++; if (ifc.avs_waitrequest !== 2'b10) begin errs++; $display("FAIL tf_9th got %b exp 10", ifc.avs_waitrequest); end
        vec++; if ({ifc.avs_readdatavalid, ifc.avs_readdata} !== {2'b01, 16'h0F0F}) begin errs++; $display("FAIL tf_r0 got %b %h exp 01 0f0f", ifc.avs_readdatavalid, ifc.avs_readdata); end
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            ifc.avs_read          = '0;
            ifc.bus_resp_valid    = (i < 8);
            ifc.bus_resp_readdata = 16'h0100 + 16'(i);
            #1;
            if (i > 0) begin
                vec++; if ({ifc.avs_readdatavalid, ifc.avs_readdata} !== {2'b01, 16'h0100 + 16'(i - 1)})
                    begin errs++; $display("FAIL tf_drain[%0d] got %b %h exp 01 %h", i, ifc.avs_readdatavalid, ifc.avs_readdata, 16'h0100 + 16'(i - 1)); end
            end
        end
        @(negedge clk);
        #1;
        vec++; if (ifc.avs_readdatavalid !== 2'b00) begin errs++; $display("FAIL tf_end_rdv got %b exp 00", ifc.avs_readdatavalid); end
        vec++; if (tag_err_o !== 1'b0) begin errs++; $display("FAIL tf_tagerr got %b exp 0", tag_err_o); end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        ifc.bus_req_ready        = 1'b0;
        ifc.avs_write[0]         = 1'b1;
        ifc.avs_address[0 +: AW] = 24'h123456;
        ifc.avs_writedata        = {16'h0000, 16'hBEEF};
        ifc.avs_byteenable       = 4'b0001;
        #1;
        vec++; if (ifc.avs_waitrequest !== 2'b10) begin errs++; $display("FAIL bp_grant got %b exp 10", ifc.avs_waitrequest); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ifc.avs_write             = 2'b11;
            ifc.avs_address[0 +: AW]  = 24'h654321;
            ifc.avs_address[AW +: AW] = 24'h111111;
            ifc.avs_writedata         = {16'hCAFE, 16'h0DAD};
            ifc.avs_byteenable        = 4'b1110;
            #1;
            vec++; if (ifc.avs_waitrequest !== 2'b11) begin errs++; $display("FAIL bp_wait[%0d] got %b exp 11", i, ifc.avs_waitrequest); end
            vec++; if ({ifc.bus_req_valid, ifc.bus_req_write, ifc.bus_req_address, ifc.bus_req_writedata, ifc.bus_req_byteenable} !== {2'b11, 24'h123456, 16'hBEEF, 2'b01})
                begin errs++; $display("FAIL bp_hold[%0d] got %b%b %h %h %b exp 11 123456 beef 01", i, ifc.bus_req_valid, ifc.bus_req_write, ifc.bus_req_address, ifc.bus_req_writedata, ifc.bus_req_byteenable); end
        end
        @(negedge clk);
        ifc.bus_req_ready = 1'b1;
        #1;
        vec++; if (ifc.avs_waitrequest !== 2'b01) begin errs++; $display("FAIL bp_refill got %b exp 01", ifc.avs_waitrequest); end
        vec++; if (ifc.bus_req_address !== 24'h123456) begin errs++; $display("FAIL bp_drain_addr got %h exp 123456", ifc.bus_req_address); end
        @(negedge clk);
        ifc.avs_write = '0;
        #1;
        vec++; if ({ifc.bus_req_valid, ifc.bus_req_address, ifc.bus_req_writedata, ifc.bus_req_byteenable} !== {1'b1, 24'h111111, 16'hCAFE, 2'b11})
            begin errs++; $display("FAIL bp_next got %b %h %h %b exp 1 111111 cafe 11", ifc.bus_req_valid, ifc.bus_req_address, ifc.bus_req_writedata, ifc.bus_req_byteenable); end
        @(negedge clk);
        #1;
        vec++; if (ifc.bus_req_valid !== 1'b0) begin errs++; $display("FAIL bp_empty got %b exp 0", ifc.bus_req_valid); end
    endtask

    task automatic test_tag_err_reset();
        @(negedge clk);
        ifc.bus_resp_valid    = 1'b1;
        ifc.bus_resp_readdata = 16'h7777;
        #1;
        vec++; if (tag_err_o !== 1'b0) begin errs++; $display("FAIL te_pre got %b exp 0", tag_err_o); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            ifc.bus_resp_valid = 1'b0;
            #1;
            vec++; if (tag_err_o !== 1'b1) begin errs++; $display("FAIL te_sticky[%0d] got %b exp 1", i, tag_err_o); end
            vec++; if ({ifc.avs_readdatavalid, ifc.avs_readdata} !== {2'b00, 16'h0100 + 16'd7})
                begin errs++; $display("FAIL te_rdv[%0d] got %b %h exp 00 0107", i, ifc.avs_readdatavalid, ifc.avs_readdata); end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ifc.avs_read[1]           = 1'b1;
            ifc.avs_address[AW +: AW] = 24'h000050 + 24'(i);
            #1;
            vec++; if (ifc.avs_waitrequest !== 2'b01) begin errs++; $display("FAIL te_rd[%0d] got %b exp 01", i, ifc.avs_waitrequest); end
        end
        @(negedge clk);
        ifc.avs_read = '0;
        reset        = 1'b1;
        #1;
        vec++; if (tag_err_o !== 1'b1) begin errs++; $display("FAIL te_before_rst got %b exp 1", tag_err_o); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        vec++; if ({ifc.bus_req_valid, tag_err_o, ifc.avs_readdatavalid} !== 4'b0000)
            begin errs++; $display("FAIL te_after_rst got %b%b%b exp 0000", ifc.bus_req_valid, tag_err_o, ifc.avs_readdatavalid); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ifc.bus_resp_valid    = (i < 3);
            ifc.bus_resp_readdata = 16'h9999;
            #1;
            vec++; if ({ifc.avs_readdatavalid, ifc.avs_readdata} !== {2'b00, 16'h0000})
                begin errs++; $display("FAIL te_stale[%0d] got %b %h exp 00 0000", i, ifc.avs_readdatavalid, ifc.avs_readdata); end
        end
        vec++; if (tag_err_o !== 1'b1) begin errs++; $display("FAIL te_empty_resp got %b exp 1", tag_err_o); end
    endtask

    initial begin
        vec  = 0;
        errs = 0;
        test_reset();
        test_init();
        test_round_robin();
        test_read_order();
        test_tag_full();
        test_backpressure();
        test_tag_err_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
